// File: rtl/cache_request_initiator.sv
// Requester-side cache access endpoint: FIFO of core requests, one-cycle memRead/memWrite issue,
// blocking reads with a watchdog. Define CACHE_REQ_RETRY_EN to reissue timed-out reads before erroring.
module cache_request_initiator #(
    parameter int DATA_WIDTH               = 32,
    parameter int CACHE_BANK_ADDRESS_WIDTH = 8,
    parameter int NETWORK_ADDRESS_WIDTH    = 4,
    parameter int MY_ADDRESS               = 0,
    parameter int FIFO_DEPTH               = 4,
    parameter int TIMEOUT_CYCLES           = 64,
    parameter int MAX_RETRIES              = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                core_valid,
    output logic                                core_ready,
    input  logic                                core_write,
    input  logic [CACHE_BANK_ADDRESS_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0]               core_wdata,
    output logic                                rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_data,
    output logic                                rsp_error,
    output logic                                busy,
    output logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheAddressOut,
    output logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressOut,
    output logic                                memRead,
    output logic                                memWrite,
    output logic [DATA_WIDTH-1:0]               dataOut,
    input  logic                                readReady,
    input  logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressIn,
    input  logic [DATA_WIDTH-1:0]               cacheDataIn
);
    localparam int AW = CACHE_BANK_ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
    localparam logic [NETWORK_ADDRESS_WIDTH-1:0] MY_TAG = NETWORK_ADDRESS_WIDTH'(MY_ADDRESS);
`ifdef CACHE_REQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            req_wr_q, req_wr_d;
    logic [AW-1:0]   req_addr_q, req_addr_d;
    logic [DW-1:0]   req_data_q, req_data_d;
    logic            mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [AW-1:0]   cache_addr_q, cache_addr_d;
    logic [DW-1:0]   data_out_q, data_out_d;
    logic [NETWORK_ADDRESS_WIDTH-1:0] req_tag_q, req_tag_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    logic [AW+DW:0]  fifo_mem [FIFO_DEPTH];
    logic [AW+DW:0]  head;
    logic            push, pop, issue, match;

    assign core_ready = (count_q != CW'(FIFO_DEPTH));
    assign push       = core_valid && core_ready;
    assign pop        = (state_q == S_IDLE) && (count_q != '0);
    assign head       = fifo_mem[rd_ptr_q];
    assign match      = readReady && (requesterAddressIn == MY_TAG);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {core_write, core_addr, core_wdata};
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        count_d      = count_q + CW'(push) - CW'(pop);
        timer_d      = timer_q;
        retry_d      = retry_q;
        req_wr_d     = req_wr_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        rsp_valid_d  = 1'b0;
        rsp_error_d  = 1'b0;
        rsp_data_d   = '0;
        issue        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {req_wr_d, req_addr_d, req_data_d} = head;
                    retry_d = '0;
                    issue   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = req_wr_q ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (match) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cacheDataIn;
                    state_d     = S_IDLE;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    if (RETRY_EN && (retry_q != RW'(MAX_RETRIES))) begin
                        retry_d = retry_q + 1'b1;
                        issue   = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Network-facing outputs are high only for the single ISSUE cycle.
        mem_read_d   = issue && !req_wr_d;
        mem_write_d  = issue && req_wr_d;
        cache_addr_d = issue ? req_addr_d : '0;
        data_out_d   = (issue && req_wr_d) ? req_data_d : '0;
        req_tag_d    = issue ? MY_TAG : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            retry_q      <= '0;
            req_wr_q     <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            cache_addr_q <= '0;
            data_out_q   <= '0;
            req_tag_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            req_wr_q     <= req_wr_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            cache_addr_q <= cache_addr_d;
            data_out_q   <= data_out_d;
            req_tag_q    <= req_tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_error_q  <= rsp_error_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign busy                = (state_q != S_IDLE) || (count_q != '0);
    assign memRead             = mem_read_q;
    assign memWrite            = mem_write_q;
    assign cacheAddressOut     = cache_addr_q;
    assign dataOut             = data_out_q;
    assign requesterAddressOut = req_tag_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_error           = rsp_error_q;
    assign rsp_data            = rsp_data_q;
endmodule

// File: tb/tb_cache_request_initiator.sv
// Directed bench for cache_request_initiator (MY_ADDRESS=3, TIMEOUT_CYCLES=64, FIFO_DEPTH=4).
module tb_cache_request_initiator;
    logic        clk = 1'b0;
    logic        reset;
    logic        core_valid, core_ready, core_write;
    logic [7:0]  core_addr;
    logic [31:0] core_wdata;
    logic        rsp_valid, rsp_error, busy;
    logic [31:0] rsp_data;
    logic [7:0]  cacheAddressOut;
    logic [3:0]  requesterAddressOut;
    logic        memRead, memWrite;
    logic [31:0] dataOut;
    logic        readReady;
    logic [3:0]  requesterAddressIn;
    logic [31:0] cacheDataIn;

    int errors = 0;
    int checks = 0;

    cache_request_initiator #(
        .DATA_WIDTH(32), .CACHE_BANK_ADDRESS_WIDTH(8), .NETWORK_ADDRESS_WIDTH(4),
        .MY_ADDRESS(3), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64), .MAX_RETRIES(2)
    ) dut (
        .clk(clk), .reset(reset),
        .core_valid(core_valid), .core_ready(core_ready), .core_write(core_write),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy),
        .cacheAddressOut(cacheAddressOut), .requesterAddressOut(requesterAddressOut),
        .memRead(memRead), .memWrite(memWrite), .dataOut(dataOut),
        .readReady(readReady), .requesterAddressIn(requesterAddressIn), .cacheDataIn(cacheDataIn)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic wr, input logic [7:0] a, input logic [31:0] d);
        core_valid = 1'b1; core_write = wr; core_addr = a; core_wdata = d;
        tick();
        core_valid = 1'b0; core_write = 1'b0; core_addr = '0; core_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        core_valid = 0; core_write = 0; core_addr = 0; core_wdata = 0;
        readReady = 0; requesterAddressIn = 0; cacheDataIn = 0;
        #12;
        checks++;
        if (core_ready !== 1'b1) begin errors++; $display("FAIL reset_core_ready: got %b want 1", core_ready); end
        checks++;
        if ({busy, memRead, memWrite, rsp_valid, rsp_error} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {busy, memRead, memWrite, rsp_valid, rsp_error});
        end
        checks++;
        if ({cacheAddressOut, requesterAddressOut, dataOut, rsp_data} !== 76'h0) begin
            errors++; $display("FAIL reset_buses: got %h want 0", {cacheAddressOut, requesterAddressOut, dataOut, rsp_data});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_store();
        push_req(1'b1, 8'h12, 32'hDEADBEEF);
        checks++;
        if (memWrite !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL store_e0: memWrite=%b busy=%b want 0 1", memWrite, busy);
        end
        tick();
        checks++;
        if ({memWrite, memRead, cacheAddressOut, dataOut, requesterAddressOut} !== {2'b10, 8'h12, 32'hDEADBEEF, 4'd3}) begin
            errors++; $display("FAIL store_pulse: got %b%b %h %h %h want 10 12 deadbeef 3",
                               memWrite, memRead, cacheAddressOut, dataOut, requesterAddressOut);
        end
        tick();
        checks++;
        if ({memWrite, cacheAddressOut, dataOut, requesterAddressOut, busy, rsp_valid} !== 47'h0) begin
            errors++; $display("FAIL store_after: memWrite=%b addr=%h data=%h tag=%h busy=%b rsp_valid=%b want all 0",
                               memWrite, cacheAddressOut, dataOut, requesterAddressOut, busy, rsp_valid);
        end
    endtask

    task automatic test_load();
        push_req(1'b0, 8'h20, 32'h0);
        tick();
        checks++;
        if ({memRead, memWrite, cacheAddressOut, dataOut, requesterAddressOut} !== {2'b10, 8'h20, 32'h0, 4'd3}) begin
            errors++; $display("FAIL load_pulse: got %b%b %h %h %h want 10 20 0 3",
                               memRead, memWrite, cacheAddressOut, dataOut, requesterAddressOut);
        end
        tick(); tick();
        readReady = 1'b1; requesterAddressIn = 4'd3; cacheDataIn = 32'hCAFEF00D;
        tick();
        readReady = 1'b0; requesterAddressIn = 0; cacheDataIn = 0;
        checks++;
        if ({rsp_valid, rsp_error, rsp_data} !== {2'b10, 32'hCAFEF00D}) begin
            errors++; $display("FAIL load_rsp: got %b%b %h want 10 cafef00d", rsp_valid, rsp_error, rsp_data);
        end
        tick();
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL load_rsp_end: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_foreign_and_stale();
        readReady = 1'b1; requesterAddressIn = 4'd3; cacheDataIn = 32'h55555555;
        tick();
        readReady = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stale_idle: rsp_valid=%b want 0", rsp_valid); end
        push_req(1'b0, 8'h30, 32'h0);
        tick(); tick();
        readReady = 1'b1; requesterAddressIn = 4'd5; cacheDataIn = 32'h11111111;
        tick();
        checks++;
        if ({rsp_valid, busy} !== 2'b01) begin
            errors++; $display("FAIL foreign_tag: rsp_valid=%b busy=%b want 0 1", rsp_valid, busy);
        end
        requesterAddressIn = 4'd3; cacheDataIn = 32'h22222222;
        tick();
        readReady = 1'b0; requesterAddressIn = 0; cacheDataIn = 0;
        checks++;
        if ({rsp_valid, rsp_error, rsp_data} !== {2'b10, 32'h22222222}) begin
            errors++; $display("FAIL own_tag: got %b%b %h want 10 22222222", rsp_valid, rsp_error, rsp_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a_seen [4];
        logic [31:0] d_seen [4];
        int          c_seen [4];
        int          np;
        push_req(1'b0, 8'h40, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            core_valid = 1'b1; core_write = 1'b1; core_addr = 8'h50 + 8'(i); core_wdata = 32'h1000 + 32'(i);
            checks++;
            if (core_ready !== (i < 4)) begin
                errors++; $display("FAIL queue_ready_%0d: got %b want %b", i, core_ready, (i < 4));
            end
            tick();
        end
        core_valid = 1'b0; core_write = 1'b0;
        checks++;
        if ({core_ready, busy, memWrite} !== 3'b010) begin
            errors++; $display("FAIL queue_full_hold: ready=%b busy=%b memWrite=%b want 0 1 0", core_ready, busy, memWrite);
        end
        readReady = 1'b1; requesterAddressIn = 4'd3; cacheDataIn = 32'hABCD0123;
        tick();
        readReady = 1'b0; requesterAddressIn = 0; cacheDataIn = 0;
        checks++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'hABCD0123}) begin
            errors++; $display("FAIL queue_load_rsp: got %b %h want 1 abcd0123", rsp_valid, rsp_data);
        end
        np = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (memWrite) begin
                if (np < 4) begin a_seen[np] = cacheAddressOut; d_seen[np] = dataOut; c_seen[np] = k; end
                np++;
            end
        end
        checks++;
        if (np !== 4) begin errors++; $display("FAIL queue_count: got %0d pulses want 4", np); end
        for (int i = 0; i < 4 && i < np; i++) begin
            checks++;
            if (a_seen[i] !== 8'h50 + 8'(i) || d_seen[i] !== 32'h1000 + 32'(i) || c_seen[i] !== 2 * i + 1) begin
                errors++; $display("FAIL queue_order_%0d: got addr %h data %h cycle %0d want %h %h %0d",
                                   i, a_seen[i], d_seen[i], c_seen[i], 8'h50 + 8'(i), 32'h1000 + 32'(i), 2 * i + 1);
            end
        end
        checks++;
        if ({core_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL queue_drained: ready=%b busy=%b want 1 0", core_ready, busy);
        end
    endtask

    task automatic test_timeout();
        int n, reads, exp_n, exp_reads;
        bit found;
`ifdef CACHE_REQ_RETRY_EN
        exp_n = 195; exp_reads = 2;
`else
        exp_n = 65;  exp_reads = 0;
`endif
        cacheDataIn = 32'h77777777;
        push_req(1'b0, 8'h60, 32'h0);
        tick();
        checks++;
        if (memRead !== 1'b1) begin errors++; $display("FAIL timeout_issue: memRead=%b want 1", memRead); end
        n = 0; reads = 0; found = 0;
        for (int k = 1; k <= 400 && !found; k++) begin
            tick();
            if (memRead) begin
                reads++;
                checks++;
                if (cacheAddressOut !== 8'h60) begin
                    errors++; $display("FAIL retry_addr: got %h want 60", cacheAddressOut);
                end
            end
            if (rsp_valid) begin found = 1; n = k; end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL timeout_never: rsp_valid not seen within 400 cycles, want at %0d", exp_n);
        end else begin
            checks++;
            if (n !== exp_n) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", n, exp_n); end
            checks++;
            if ({rsp_error, rsp_data} !== {1'b1, 32'h0}) begin
                errors++; $display("FAIL timeout_rsp: got %b %h want 1 0", rsp_error, rsp_data);
            end
        end
        checks++;
        if (reads !== exp_reads) begin errors++; $display("FAIL timeout_reissues: got %0d want %0d", reads, exp_reads); end
        cacheDataIn = 0;
        tick();
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL timeout_end: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int wr_seen;
        push_req(1'b0, 8'h70, 32'h0);
        tick(); tick();
        push_req(1'b1, 8'h71, 32'h12345678);
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({core_ready, busy, memRead, memWrite, rsp_valid, rsp_error} !== 6'b100000) begin
            errors++; $display("FAIL reset_mid_flags: got %b want 100000", {core_ready, busy, memRead, memWrite, rsp_valid, rsp_error});
        end
        #3;
        reset = 1'b0;
        tick();
        readReady = 1'b1; requesterAddressIn = 4'd3; cacheDataIn = 32'h99999999;
        tick();
        readReady = 1'b0; requesterAddressIn = 0; cacheDataIn = 0;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL reset_late_rsp: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
        wr_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (memWrite || memRead || rsp_valid) wr_seen++;
        end
        checks++;
        if (wr_seen !== 0) begin errors++; $display("FAIL reset_flush: got %0d activity cycles want 0", wr_seen); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_foreign_and_stale();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
